// File: rtl/mlm_pkg.sv
// Shared definitions for the Hamming(21,16) link code used by mlm_par and mlm_chk.
// Codeword positions are 1-based; check bit k sits at position 2^k.
package mlm_pkg;

    localparam int DATA_W = 16;
    localparam int PAR_W  = 5;
    localparam int CW_LEN = 21;

    typedef logic [0:DATA_W-1] data_t;
    typedef logic [0:PAR_W-1]  par_t;
    typedef logic [0:PAR_W-1]  syn_t;

    // Codeword position of data bit idx: the idx-th non-power-of-two position.
    function automatic int pos_map(input int idx);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int p = 1; p <= CW_LEN; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = p;
                n++;
            end
        end
        return r;
    endfunction

    function automatic par_t calc_par(input data_t d);
        par_t p;
        int   pos;
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            pos = pos_map(i);
            for (int k = 0; k < PAR_W; k++) begin
                if (((pos >> k) & 1) != 0) p[k] = p[k] ^ d[i];
            end
        end
        return p;
    endfunction

    // Numeric value of a syndrome; s[k] carries weight 2^k.
    function automatic int syn_val(input syn_t s);
        int v;
        v = 0;
        for (int k = 0; k < PAR_W; k++) begin
            if (s[k]) v = v + (1 << k);
        end
        return v;
    endfunction

    function automatic logic is_corr(input syn_t s);
        return (syn_val(s) != 0) && (syn_val(s) <= CW_LEN);
    endfunction

    function automatic logic is_uncorr(input syn_t s);
        return syn_val(s) > CW_LEN;
    endfunction

endpackage

// File: rtl/mlm_syn.sv
// Combinational syndrome and single-bit correction mask for one received word.
// Check-bit and out-of-range syndromes match no data position, so the mask stays zero.
module mlm_syn
    import mlm_pkg::*;
(
    input  logic [0:15] data,
    input  logic [0:4]  par,
    output logic [0:4]  syn,
    output logic [0:15] mask
);

    int sv;

    always_comb begin
        syn  = calc_par(data) ^ par;
        sv   = syn_val(syn);
        mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (sv == pos_map(i));
        end
    end

endmodule

// File: rtl/mlm_chk.sv
// Receive-side Hamming(21,16) checker/corrector: two-stage pipeline with valid/ready on both
// sides, saturating corrected/uncorrectable counters and a sticky error flag.
module mlm_chk
    import mlm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:15]      in_data,
    input  logic [0:4]       in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:15]      out_data,
    output logic [0:4]       out_syn,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    output logic             err_sticky
);

    logic        adv;
    logic        fire;
    logic [0:4]  syn_c;
    logic [0:15] mask_c;

    logic        s1_valid;
    logic [0:15] s1_data;
    logic [0:4]  s1_syn;
    logic [0:15] s1_mask;

    // Both stages move together, so a stall only depends on the output register.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign fire     = out_valid && out_ready;

    mlm_syn u_syn (
        .data (in_data),
        .par  (in_par),
        .syn  (syn_c),
        .mask (mask_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_mask  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_syn   <= syn_c;
            s1_mask  <= mask_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_syn    <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else if (adv) begin
            out_valid  <= s1_valid;
            out_data   <= s1_data ^ s1_mask;
            out_syn    <= s1_syn;
            out_corr   <= is_corr(s1_syn);
            out_uncorr <= is_uncorr(s1_syn);
        end
    end

    // Counters track delivered words only; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            err_sticky <= 1'b0;
        end else if (fire) begin
            if (out_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_uncorr && (uncorr_cnt != '1)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
            if (out_corr || out_uncorr) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mlm_chk.sv
// Scoreboard bench for mlm_chk: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares on every output handshake.
module tb_mlm_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] in_data;
    logic [0:4]  in_par;
    logic        out_valid;
    logic        out_ready;
    logic [0:15] out_data;
    logic [0:4]  out_syn;
    logic        out_corr;
    logic        out_uncorr;
    logic        clr_cnt;
    logic [3:0]  corr_cnt;
    logic [3:0]  uncorr_cnt;
    logic        err_sticky;

    typedef struct {
        logic [0:15] data;
        int          syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    mlm_chk #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_syn    (out_syn),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .err_sticky (err_sticky)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic int synv(input logic [0:4] s);
        int v;
        v = 0;
        for (int k = 0; k < 5; k++) if (s[k]) v += (1 << k);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_syn", synv(out_syn), e.syn);
                chk("out_corr", out_corr, e.corr);
                chk("out_uncorr", out_uncorr, e.uncorr);
            end
        end
    end

    task automatic send(input logic [0:15] d, input logic [0:4] p, input logic [0:15] ed,
                        input int es, input logic ec, input logic eu);
        exp_t x;
        int   n;
        bit   acc;
        x.data   = ed;
        x.syn    = es;
        x.corr   = ec;
        x.uncorr = eu;
        sb.push_back(x);
        in_valid = 1'b1;
        in_data  = d;
        in_par   = p;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", n, 0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = '0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        chk("rst_uncorr_cnt", uncorr_cnt, 0);
        chk("rst_sticky", err_sticky, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // Clean word.
        send(16'h0000, 5'b00000, 16'h0000, 0, 1'b0, 1'b0);
        drain();
        chk("clean_corr_cnt", corr_cnt, 0);
        chk("clean_sticky", err_sticky, 0);

        // Data bit 0 (position 3) flipped.
        send(16'h8000, 5'b00000, 16'h0000, 3, 1'b1, 1'b0);
        drain();
        chk("dbit_corr_cnt", corr_cnt, 1);
        chk("dbit_sticky", err_sticky, 1);

        // Check bit p[2] flipped.
        send(16'h0000, 5'b00100, 16'h0000, 4, 1'b1, 1'b0);
        drain();
        chk("pbit_corr_cnt", corr_cnt, 2);

        // Syndrome 31: uncorrectable.
        send(16'h0000, 5'b11111, 16'h0000, 31, 1'b0, 1'b1);
        drain();
        chk("unc_uncorr_cnt", uncorr_cnt, 1);
        chk("unc_corr_cnt", corr_cnt, 2);

        // dead with data bit 15 (position 21) flipped.
        send(16'hdeac, 5'b11111, 16'hdead, 21, 1'b1, 1'b0);
        drain();
        chk("pos21_corr_cnt", corr_cnt, 3);

        // Backpressure: three clean words with the consumer stalled.
        out_ready = 1'b0;
        fork
            begin
                send(16'hdead, 5'b11111, 16'hdead, 0, 1'b0, 1'b0);
                send(16'hbeef, 5'b01100, 16'hbeef, 0, 1'b0, 1'b0);
                send(16'h0055, 5'b10011, 16'h0055, 0, 1'b0, 1'b0);
            end
            begin
                wait_out_valid("bp_out_valid");
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold_data", out_data, 16'hdead);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_corr_cnt", corr_cnt, 3);

        // 17 more corrected words saturate the 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            case (i % 3)
                0: send(16'h0001, 5'b00000, 16'h0000, 21, 1'b1, 1'b0);
                1: send(16'h0000, 5'b10000, 16'h0000, 1, 1'b1, 1'b0);
                default: send(16'h0100, 5'b00000, 16'h0000, 12, 1'b1, 1'b0);
            endcase
        end
        drain();
        chk("sat_corr_cnt", corr_cnt, 15);
        chk("sat_uncorr_cnt", uncorr_cnt, 1);

        // Clear coinciding with a corrected handshake.
        out_ready = 1'b0;
        send(16'h8000, 5'b00000, 16'h0000, 3, 1'b1, 1'b0);
        wait_out_valid("clr_out_valid");
        clr_cnt   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_corr_cnt", corr_cnt, 0);
        chk("clr_uncorr_cnt", uncorr_cnt, 0);
        chk("clr_sticky", err_sticky, 0);
        drain();

        // Reset with a corrected word in flight discards it.
        out_ready = 1'b0;
        send(16'h8000, 5'b00000, 16'h0000, 3, 1'b1, 1'b0);
        wait_out_valid("mid_out_valid");
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_corr", out_corr, 0);
        chk("mid_rst_out_syn", synv(out_syn), 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_rst_corr_cnt", corr_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mlm_chk.md
Name: mlm_chk

Overview:
- Receive-side checker and corrector for the 16-bit data / 5-bit parity words produced by mlm_par.
- Recomputes parity, forms a syndrome, and corrects any single-bit error in data or parity.
- Flags uncorrectable syndromes and keeps saturating error counters.
- 2-stage pipeline with valid/ready handshakes on both sides; sits between the link/storage and the consumer.

Parameters:
- CNT_W, 16, width of the corrected and uncorrectable event counters (saturating).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  checker can accept a word this cycle.
- in_data  in  [0:15]  received data, same bit order as mlm_par input.
- in_par  in  [0:4]  received parity, same bit order as mlm_par output.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  [0:15]  corrected data.
- out_syn  out  [0:4]  syndrome of the word; p[k] weight 2^k.
- out_corr  out  1  single-bit error corrected (syndrome 1..21).
- out_uncorr  out  1  uncorrectable (syndrome 22..31); out_data is raw in_data.
- clr_cnt  in  1  synchronous clear of counters and sticky flag.
- corr_cnt  out  CNT_W  count of corrected words delivered.
- uncorr_cnt  out  CNT_W  count of uncorrectable words delivered.
- err_sticky  out  1  set by any delivered corr or uncorr word; cleared only by rst/clr_cnt.

Behaviour:
- Code: Hamming(21,16).
  - Check bit p[k] sits at codeword position 2^k (1,2,4,8,16).
  - Data bits in_data[0..15] occupy the non-power-of-two positions 3,5,6,7,9..15,17..21, in ascending order.
  - p[k] = XOR of the data bits whose position has bit k set.
- Syndrome: recomputed parity XOR in_par. Its numeric value is the erroneous position.
  - 0: clean; out_corr=0, out_uncorr=0.
  - Power of two: check-bit error; data passes unchanged, out_corr=1.
  - Other value in 1..21: flip the mapped data bit, out_corr=1.
  - 22..31: out_uncorr=1, data unchanged.
- Pipeline:
  - S1 registers data and syndrome. S2 registers corrected data and flags; S2 drives the out_* ports.
  - Latency is 2 cycles from input handshake to out_valid when not stalled.
- Handshake:
  - adv = !out_valid || out_ready. in_ready = adv; in_ready is combinational from out_ready only.
  - When adv=1, both stages shift and bubbles propagate as valid=0.
  - When adv=0, both stages hold and out_* stay stable.
  - in_valid with in_ready=0 is not consumed.
  - Full throughput: 1 word/cycle while out_ready=1.
- Counters:
  - Increment on the output handshake (out_valid && out_ready) carrying corr or uncorr.
  - Saturate at all-ones with no wrap.
  - clr_cnt has priority over a same-cycle increment; result is 0.
- Reset:
  - Values: out_valid=0, stage valids=0, counters=0, err_sticky=0, out_data/out_syn/out_corr/out_uncorr=0.
  - Reset mid-stream discards in-flight words.
  - in_ready is 1 the cycle after reset deasserts.

Decomposition:
- Package mlm_pkg holds:
  - DATA_W=16, PAR_W=5, CW_LEN=21.
  - Typedefs data_t [0:15], par_t [0:4], syn_t [0:4].
  - The position-to-data-bit map as a constant function.
  - Function calc_par(data_t) returning par_t, shared with mlm_par.
- One sub-module, mlm_syn: combinational syndrome and correction mask from (data, par).

Test Plan:
- Clean: in_data=16'h0000, in_par=0 -> 2 cycles later out_data=16'h0000, out_syn=0, corr=0, uncorr=0, counters unchanged.
- Data single-bit: in_data=16'h8000 (bit 0 = position 3), in_par=0 -> out_syn=3, out_data=16'h0000, out_corr=1, corr_cnt=1, err_sticky=1.
- Parity single-bit: in_data=16'h0000, in_par with only p[2] set -> out_syn=4, out_data=16'h0000, out_corr=1.
- Uncorrectable: in_data=16'h0000, in_par=5'b11111 -> out_syn=31, out_uncorr=1, out_data=16'h0000, uncorr_cnt=1.
- Backpressure: stream 16'hdead, 16'hbeef, 16'h0055 (each with calc_par parity) and hold out_ready=0 for 3 cycles -> in_ready=0, out_data held stable, no loss or duplication; after release, all three appear in order.
- Saturation and clear: CNT_W=4, 17 corrected words -> corr_cnt=4'hF. Then clr_cnt together with a corrected handshake -> corr_cnt=0, err_sticky=0.
